// File: rtl/ssm_pkg.sv
// ssm_pkg: shared FSM encoding, response status codes, default widths
// and small helpers for the SSM host bridge.
package ssm_pkg;

  // Default a2rtap address/data widths.
  localparam int SSM_ADDR_W = 8;
  localparam int SSM_DATA_W = 32;

  // Width of the saturating error counter.
  localparam int SSM_ERR_W = 8;

  // Bridge sequencing states.
  typedef enum logic [1:0] {
    SSM_IDLE  = 2'b00,
    SSM_ISSUE = 2'b01,
    SSM_WAIT  = 2'b10,
    SSM_RESP  = 2'b11
  } ssm_state_e;

  // Response status codes reported on rsp_status.
  localparam logic [1:0] SSM_ST_OK  = 2'b00;
  localparam logic [1:0] SSM_ST_ERR = 2'b01;
  localparam logic [1:0] SSM_ST_TMO = 2'b10;

  // Increment that parks at all-ones instead of wrapping.
  function automatic logic [SSM_ERR_W-1:0] ssm_sat_inc(input logic [SSM_ERR_W-1:0] val);
    logic [SSM_ERR_W-1:0] res;
    if (val == {SSM_ERR_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + {{(SSM_ERR_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  // True for completion codes that count as failures.
  function automatic logic ssm_is_fail(input logic [1:0] status);
    return (status != SSM_ST_OK);
  endfunction

endpackage

// File: rtl/ssm_timeout_ctr.sv
// ssm_timeout_ctr: counts cycles spent waiting for a2rtap completion.
// The count is zeroed by clear (asserted on entry to WAIT) and advances on
// every enabled cycle.  expired is high during the TIMEOUT_CYC-th enabled
// cycle after the clear, so a transaction that never sees ready spends
// exactly TIMEOUT_CYC cycles in WAIT.  TIMEOUT_CYC must be at least 1.
module ssm_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset_,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Counter only needs to reach TIMEOUT_CYC-1.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_r;

  // Wait-cycle counter: cleared on WAIT entry, counts enabled cycles, parks at the last value.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && (count_r != CNT_LAST)) begin
      count_r <= count_r + CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == CNT_LAST);

endmodule

// File: rtl/ssm_host_bridge.sv
// ssm_host_bridge: turns host command/response handshakes into single
// a2rtap master transactions (level strobes held until ready or timeout),
// reports OK/ERROR/TIMEOUT per command and keeps a saturating failure count.
// Every output is driven straight from a register.
module ssm_host_bridge
  import ssm_pkg::*;
#(
  parameter int ADDR_W      = SSM_ADDR_W,
  parameter int DATA_W      = SSM_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_,
  // Host command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // Host response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_status,
  // a2rtap master side
  output logic [ADDR_W-1:0] a2rtap_master_ifc_address,
  output logic [DATA_W-1:0] a2rtap_master_ifc_write_data,
  output logic              a2rtap_master_ifc_read,
  output logic              a2rtap_master_ifc_write,
  input  logic [DATA_W-1:0] a2rtap_master_ifc_read_data,
  input  logic              a2rtap_master_ifc_ready,
  input  logic              a2rtap_master_ifc_error,
  // Status
  output logic [7:0]        err_count
);

  ssm_state_e        state_r;
  ssm_state_e        next_state_s;

  logic              cmd_ready_r;
  logic              is_write_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              rd_strobe_r;
  logic              wr_strobe_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic [1:0]        rsp_status_r;
  logic [7:0]        err_count_r;

  logic              accept_s;
  logic              issue_s;
  logic              complete_s;
  logic              rsp_done_s;
  logic [1:0]        cmpl_status_s;
  logic [DATA_W-1:0] cmpl_rdata_s;
  logic              ctr_clear_s;
  logic              ctr_enable_s;
  logic              ctr_expired_s;

  ssm_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset_  (reset_),
    .clear   (ctr_clear_s),
    .enable  (ctr_enable_s),
    .expired (ctr_expired_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_r <= SSM_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and completion decode; ready is checked before the timeout so it wins a tie.
  always_comb begin
    next_state_s  = state_r;
    accept_s      = 1'b0;
    issue_s       = 1'b0;
    complete_s    = 1'b0;
    rsp_done_s    = 1'b0;
    cmpl_status_s = SSM_ST_OK;
    cmpl_rdata_s  = {DATA_W{1'b0}};
    ctr_clear_s   = 1'b0;
    ctr_enable_s  = 1'b0;
    case (state_r)
      SSM_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          accept_s     = 1'b1;
          next_state_s = SSM_ISSUE;
        end else begin
          next_state_s = SSM_IDLE;
        end
      end
      SSM_ISSUE: begin
        issue_s      = 1'b1;
        ctr_clear_s  = 1'b1;
        next_state_s = SSM_WAIT;
      end
      SSM_WAIT: begin
        ctr_enable_s = 1'b1;
        if (a2rtap_master_ifc_ready) begin
          complete_s   = 1'b1;
          next_state_s = SSM_RESP;
          if (a2rtap_master_ifc_error) begin
            cmpl_status_s = SSM_ST_ERR;
            cmpl_rdata_s  = {DATA_W{1'b0}};
          end else if (is_write_r) begin
            cmpl_status_s = SSM_ST_OK;
            cmpl_rdata_s  = {DATA_W{1'b0}};
          end else begin
            cmpl_status_s = SSM_ST_OK;
            cmpl_rdata_s  = a2rtap_master_ifc_read_data;
          end
        end else if (ctr_expired_s) begin
          complete_s    = 1'b1;
          cmpl_status_s = SSM_ST_TMO;
          cmpl_rdata_s  = {DATA_W{1'b0}};
          next_state_s  = SSM_RESP;
        end else begin
          next_state_s = SSM_WAIT;
        end
      end
      SSM_RESP: begin
        if (rsp_valid_r && rsp_ready) begin
          rsp_done_s   = 1'b1;
          next_state_s = SSM_IDLE;
        end else begin
          next_state_s = SSM_RESP;
        end
      end
      default: begin
        next_state_s = SSM_IDLE;
      end
    endcase
  end

  // cmd_ready is high exactly while the registered state is IDLE (low through reset).
  always_ff @(posedge clk) begin
    if (!reset_) begin
      cmd_ready_r <= 1'b0;
    end else begin
      cmd_ready_r <= (next_state_s == SSM_IDLE);
    end
  end

  // Command capture on acceptance; cmd_* is ignored at all other times.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      is_write_r <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      is_write_r <= cmd_write;
      addr_r     <= cmd_addr;
      wdata_r    <= cmd_wdata;
    end else begin
      is_write_r <= is_write_r;
      addr_r     <= addr_r;
      wdata_r    <= wdata_r;
    end
  end

  // a2rtap strobes: raised leaving ISSUE, held through WAIT, dropped after completion.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      rd_strobe_r <= 1'b0;
      wr_strobe_r <= 1'b0;
    end else if (issue_s) begin
      rd_strobe_r <= ~is_write_r;
      wr_strobe_r <= is_write_r;
    end else if (complete_s) begin
      rd_strobe_r <= 1'b0;
      wr_strobe_r <= 1'b0;
    end else begin
      rd_strobe_r <= rd_strobe_r;
      wr_strobe_r <= wr_strobe_r;
    end
  end

  // Response holding register: loaded on completion, held until the host takes it.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      rsp_valid_r  <= 1'b0;
      rsp_rdata_r  <= {DATA_W{1'b0}};
      rsp_status_r <= SSM_ST_OK;
    end else if (complete_s) begin
      rsp_valid_r  <= 1'b1;
      rsp_rdata_r  <= cmpl_rdata_s;
      rsp_status_r <= cmpl_status_s;
    end else if (rsp_done_s) begin
      rsp_valid_r  <= 1'b0;
      rsp_rdata_r  <= {DATA_W{1'b0}};
      rsp_status_r <= SSM_ST_OK;
    end else begin
      rsp_valid_r  <= rsp_valid_r;
      rsp_rdata_r  <= rsp_rdata_r;
      rsp_status_r <= rsp_status_r;
    end
  end

  // Saturating count of ERROR and TIMEOUT completions.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      err_count_r <= 8'h00;
    end else if (complete_s && ssm_is_fail(cmpl_status_s)) begin
      err_count_r <= ssm_sat_inc(err_count_r);
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign cmd_ready                    = cmd_ready_r;
  assign rsp_valid                    = rsp_valid_r;
  assign rsp_rdata                    = rsp_rdata_r;
  assign rsp_status                   = rsp_status_r;
  assign a2rtap_master_ifc_address    = addr_r;
  assign a2rtap_master_ifc_write_data = wdata_r;
  assign a2rtap_master_ifc_read       = rd_strobe_r;
  assign a2rtap_master_ifc_write      = wr_strobe_r;
  assign err_count                    = err_count_r;

endmodule

// File: tb/tb_ssm_host_bridge.sv
// tb_ssm_host_bridge: directed stimulus with a response scoreboard.
// Stimulus pushes expected {status, rdata} per command; a monitor pops and
// compares on every response handshake.  A responder model drives the
// a2rtap side with a programmable ready delay, error and read data.
module tb_ssm_host_bridge;
  import ssm_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TMO    = 255;

  logic              clk = 1'b0;
  logic              reset_;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_status;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rd, m_wr;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready, m_error;
  logic [7:0]        err_count;

  ssm_host_bridge #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk                          (clk),
    .reset_                       (reset_),
    .cmd_valid                    (cmd_valid),
    .cmd_ready                    (cmd_ready),
    .cmd_write                    (cmd_write),
    .cmd_addr                     (cmd_addr),
    .cmd_wdata                    (cmd_wdata),
    .rsp_valid                    (rsp_valid),
    .rsp_ready                    (rsp_ready),
    .rsp_rdata                    (rsp_rdata),
    .rsp_status                   (rsp_status),
    .a2rtap_master_ifc_address    (m_addr),
    .a2rtap_master_ifc_write_data (m_wdata),
    .a2rtap_master_ifc_read       (m_rd),
    .a2rtap_master_ifc_write      (m_wr),
    .a2rtap_master_ifc_read_data  (m_rdata),
    .a2rtap_master_ifc_ready      (m_ready),
    .a2rtap_master_ifc_error      (m_error),
    .err_count                    (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic [1:0]  st;
    logic [31:0] rd;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   rsp_seen = 0;
  int   first_valid_cyc = 0;
  logic prev_valid = 1'b0;
  int   overlap = 0;
  int   exp_err = 0;

  // Monitor: latency bookkeeping and comparison on each response handshake.
  always @(negedge clk) begin
    if (rsp_valid && !prev_valid) first_valid_cyc = cyc;
    prev_valid = rsp_valid;
    if (m_rd && m_wr) overlap++;
    if (reset_ && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_status", {30'd0, rsp_status}, {30'd0, mon_e.st});
        chk("rsp_rdata", rsp_rdata, mon_e.rd);
      end
      rsp_seen++;
    end
  end

  // Responder model for the a2rtap side.
  int          cfg_delay = 0;
  bit          cfg_err = 1'b0;
  bit          cfg_noise = 1'b0;
  logic [31:0] cfg_data = 32'h0;
  int          scnt = 0;
  int          last_len = 0;
  logic [7:0]  last_addr = 8'h0;
  logic [31:0] last_wdata = 32'h0;
  logic        last_is_wr = 1'b0;
  int          hold_bad = 0;

  always @(posedge clk) begin
    #1;
    if (m_rd || m_wr) begin
      scnt = scnt + 1;
      if (scnt == 1) begin
        last_addr  = m_addr;
        last_wdata = m_wdata;
        last_is_wr = m_wr;
      end else if (m_addr != last_addr || m_wdata != last_wdata || m_wr != last_is_wr) begin
        hold_bad++;
      end
    end else begin
      if (scnt != 0) last_len = scnt;
      scnt = 0;
    end
    m_ready = (scnt != 0) && (scnt == cfg_delay + 1);
    m_error = m_ready ? cfg_err : (cfg_noise && scnt != 0);
    m_rdata = m_ready ? cfg_data : 32'hBAD0_BAD0;
  end

  task automatic wait_rsp(input int seen0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      if (rsp_seen != seen0) ok = 1'b1;
    end
    chk("rsp_arrived", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_accept(output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
    end
    chk("cmd_accepted", {31'd0, ok}, 32'd1);
  endtask

  // One complete command with rsp_ready held high.
  task automatic do_cmd(input logic w, input logic [7:0] a, input logic [31:0] wd,
                        input int delay, input bit err, input bit noise, input logic [31:0] rdat,
                        input logic [1:0] est, input logic [31:0] erd,
                        input int elen, input int elat);
    exp_t e;
    int   acc_cyc;
    int   seen0;
    cfg_delay = delay; cfg_err = err; cfg_noise = noise; cfg_data = rdat;
    e.st = est; e.rd = erd;
    exp_q.push_back(e);
    if (est != SSM_ST_OK) exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    seen0 = rsp_seen;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    wait_accept(acc_cyc);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~wd;
    wait_rsp(seen0);
    chk("latency", first_valid_cyc - acc_cyc, elat);
    chk("strobe_len", last_len, elen);
    chk("strobe_addr", {24'd0, last_addr}, {24'd0, a});
    chk("strobe_is_write", {31'd0, last_is_wr}, {31'd0, w});
    if (w) chk("strobe_wdata", last_wdata, wd);
    chk("err_count", {24'd0, err_count}, exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc_a;
    int acc_b;
    int seen0;
    exp_t e;
    reset_ = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
    cmd_wdata = 32'h0; rsp_ready = 1'b1;
    m_ready = 1'b0; m_error = 1'b0; m_rdata = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
    chk("rst_strobes", {30'd0, m_rd, m_wr}, 32'd0);
    chk("rst_addr", {24'd0, m_addr}, 32'd0);
    chk("rst_wdata", m_wdata, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    @(posedge clk); #1; reset_ = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("cmd_ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // Read, ready two cycles after the strobe
    do_cmd(1'b0, 8'h12, 32'h0, 2, 1'b0, 1'b0, 32'hDEAD_BEEF, SSM_ST_OK, 32'hDEAD_BEEF, 3, 5);
    // Read with error pulses before ready (ignored)
    do_cmd(1'b0, 8'h34, 32'h0, 3, 1'b0, 1'b1, 32'h0BAD_F00D, SSM_ST_OK, 32'h0BAD_F00D, 4, 6);
    // Write OK at minimum latency: rdata must be 0 even though read_data is driven
    do_cmd(1'b1, 8'h40, 32'h1234_5678, 0, 1'b0, 1'b0, 32'hCAFE_F00D, SSM_ST_OK, 32'h0, 1, 3);
    // Write completing with error
    do_cmd(1'b1, 8'h05, 32'h0000_A5A5, 1, 1'b1, 1'b0, 32'h7777_7777, SSM_ST_ERR, 32'h0, 2, 4);
    // Read completing with error
    do_cmd(1'b0, 8'h7F, 32'h0, 0, 1'b1, 1'b0, 32'h5555_5555, SSM_ST_ERR, 32'h0, 1, 3);
    // Read that never sees ready: timeout after TMO wait cycles
    do_cmd(1'b0, 8'h33, 32'h0, 1000, 1'b0, 1'b0, 32'h9999_9999, SSM_ST_TMO, 32'h0, TMO, TMO + 2);

    // Response back-pressure with a second command waiting
    cfg_delay = 0; cfg_err = 1'b0; cfg_noise = 1'b0; cfg_data = 32'h1111_2222;
    e.st = SSM_ST_OK; e.rd = 32'h1111_2222; exp_q.push_back(e);
    e.st = SSM_ST_OK; e.rd = 32'h0;         exp_q.push_back(e);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h21; cmd_wdata = 32'h0;
    wait_accept(acc_a);
    @(posedge clk); #1;
    cmd_write = 1'b1; cmd_addr = 8'h22; cmd_wdata = 32'h0BB0_0BB0;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    chk("bp_rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1111_2222);
      chk("bp_rsp_status", {30'd0, rsp_status}, {30'd0, SSM_ST_OK});
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_addr_held", {24'd0, m_addr}, 32'h21);
      @(negedge clk);
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
    acc_b = cyc;
    seen0 = rsp_seen;
    @(posedge clk); #1; cmd_valid = 1'b0;
    wait_rsp(seen0);
    chk("second_cmd_latency", first_valid_cyc - acc_b, 32'd3);
    chk("second_cmd_addr", {24'd0, last_addr}, 32'h22);

    // Reset asserted while waiting for ready
    cfg_delay = 1000;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h66;
    wait_accept(acc_a);
    @(posedge clk); #1; cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !m_rd; i++) @(negedge clk);
    chk("wait_strobe_seen", {31'd0, m_rd}, 32'd1);
    @(posedge clk); #1; reset_ = 1'b0;
    @(posedge clk); #1;
    chk("rstw_strobes", {30'd0, m_rd, m_wr}, 32'd0);
    chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstw_err_count", {24'd0, err_count}, 32'd0);
    chk("rstw_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    reset_ = 1'b1;
    exp_err = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_cmd_ready_release", {31'd0, cmd_ready}, 32'd1);
    repeat (20) @(negedge clk);
    chk("rstw_no_stale_rsp", {31'd0, rsp_valid}, 32'd0);

    // Saturation of err_count
    for (int i = 0; i < 300; i++) begin
      do_cmd(1'b1, i[7:0], i, 0, 1'b1, 1'b0, 32'h0, SSM_ST_ERR, 32'h0, 1, 3);
    end
    chk("err_count_saturated", {24'd0, err_count}, 32'd255);

    repeat (3) @(negedge clk);
    chk("strobe_overlap", overlap, 32'd0);
    chk("strobe_hold", hold_bad, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
